// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared constants and helpers for the RV32M multiply/divide sequencer
package mdu_seq_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_ITERS = 32;

    // funct3 encodings of the M extension
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // magnitude of a value that may be two's-complement signed
    function automatic logic [MDU_XLEN-1:0] mdu_mag(input logic [MDU_XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - 64-bit accumulator with one shift-add or shift-subtract-restore step per cycle
module mdu_iter_core
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc_next
);

    // acc holds {partial high / remainder, multiplier / dividend-quotient}
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_reg;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    // one iteration of either algorithm, exposed so the final step can be used the same cycle
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_reg : {XLEN{1'b0}})};
        mul_next  = {mul_sum, acc[XLEN-1:1]};

        rem_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
        if (!div_diff[XLEN+1]) begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {acc[2*XLEN-2:0], 1'b0};
        end

        acc_next = is_div ? div_next : mul_next;
    end

    // operand capture on accept, then one step per CALC cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc   <= '0;
            b_reg <= '0;
        end else if (load) begin
            acc   <= {{XLEN{1'b0}}, a_mag};
            b_reg <= b_mag;
        end else if (step) begin
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer with valid/ready request and result
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int ITERS = MDU_ITERS
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_func,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(ITERS);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [2:0]        func_q;
    logic              neg_q;

    logic              accept;
    logic              s1_signed;
    logic              s2_signed;
    logic              s1_neg;
    logic              s2_neg;
    logic              neg_res;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic              count_last;

    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   formed;

    assign o_ready    = (state == ST_IDLE);
    assign o_valid    = (state == ST_DONE);
    assign o_busy     = (state != ST_IDLE);
    assign accept     = i_valid & o_ready & ~i_flush;
    assign count_last = (count == CNT_W'(ITERS - 1));

    // request decode: operand signedness, magnitudes, result sign and fast paths
    always_comb begin
        s1_signed = (i_func != MDU_MULHU) && (i_func != MDU_DIVU) && (i_func != MDU_REMU);
        s2_signed = (i_func == MDU_MUL) || (i_func == MDU_MULH) ||
                    (i_func == MDU_DIV) || (i_func == MDU_REM);
        s1_neg    = s1_signed & i_src1[XLEN-1];
        s2_neg    = s2_signed & i_src2[XLEN-1];
        // remainder follows the dividend; everything else follows the operand sign product
        neg_res   = (i_func == MDU_REM) ? s1_neg : (s1_neg ^ s2_neg);
        a_mag     = mdu_mag(i_src1, s1_neg);
        b_mag     = mdu_mag(i_src2, s2_neg);

        div_zero  = i_func[2] && (i_src2 == {XLEN{1'b0}});
        div_ovf   = i_func[2] && !i_func[0] &&
                    (i_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_src2 == {XLEN{1'b1}});
        fast      = div_zero | div_ovf;

        if (i_func[1]) begin
            fast_res = div_zero ? i_src1 : {XLEN{1'b0}};
        end else begin
            fast_res = div_zero ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // sign fix-up and selection of the architectural result from the final step
    always_comb begin
        prod = neg_q ? (~acc_next + 1'b1) : acc_next;
        quot = acc_next[XLEN-1:0];
        rem  = acc_next[2*XLEN-1:XLEN];
        if (!func_q[2]) begin
            formed = (func_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (func_q[1]) begin
            formed = neg_q ? (~rem + 1'b1) : rem;
        end else begin
            formed = neg_q ? (~quot + 1'b1) : quot;
        end
    end

    mdu_iter_core #(
        .XLEN     (XLEN)
    ) u_core (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .load     (accept & ~fast),
        .step     (state == ST_CALC),
        .is_div   (func_q[2]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next)
    );

    // sequencer FSM; flush beats the result handshake
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            func_q   <= '0;
            neg_q    <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        func_q <= i_func;
                        neg_q  <= neg_res;
                        count  <= '0;
                        if (fast) begin
                            o_result <= fast_res;
                            state    <= ST_DONE;
                        end else begin
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (count_last) begin
                        o_result <= formed;
                        state    <= ST_DONE;
                        count    <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_flush || i_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_func = 3'b000;
    logic [31:0] i_src1 = 32'h0;
    logic [31:0] i_src2 = 32'h0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_busy;

    int checks = 0;
    int failures = 0;

    mdu_seq dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_func   (i_func),
        .i_src1   (i_src1),
        .i_src2   (i_src2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // architectural result of an M-extension op
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f)
            MDU_MUL:    begin p = sa * sb; return p[31:0];  end
            MDU_MULH:   begin p = sa * sb; return p[63:32]; end
            MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
            MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
            MDU_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            MDU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            MDU_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // transaction-level model: busy flag, cycles until result, expected result
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_left = 0;
    logic [31:0] m_exp = 32'h0;

    always @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (!m_busy) begin
            if (i_valid && !i_flush) begin
                m_busy  <= 1'b1;
                m_exp   <= ref_res(i_func, i_src1, i_src2);
                m_left  <= is_fast(i_func, i_src1, i_src2) ? 0 : 32;
                m_valid <= is_fast(i_func, i_src1, i_src2);
            end
        end else if (i_flush) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_valid) begin
            if (i_ready) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) m_valid <= 1'b1;
        end
    end

    // per-cycle comparison of the DUT against the model
    always @(negedge i_clock) begin
        chk("cmp_ready", 32'(o_ready), 32'(!m_busy));
        chk("cmp_busy",  32'(o_busy),  32'(m_busy));
        chk("cmp_valid", 32'(o_valid), 32'(m_valid));
        if (m_valid) chk("cmp_result", o_result, m_exp);
    end

    // directed op with literal expectations for result and latency
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input logic [31:0] exp_res,
                          input int exp_lat);
        int lat;
        @(negedge i_clock);
        chk({name, "_ready_in"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_func  = f;
        i_src1  = a;
        i_src2  = b;
        i_ready = (hold == 0);
        @(negedge i_clock);
        i_valid = 1'b0;
        i_src1  = $urandom;
        i_src2  = $urandom;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (o_valid) begin
                lat = j + 1;
                break;
            end
            @(negedge i_clock);
            i_src1 = $urandom;
            i_func = 3'($urandom_range(0, 7));
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, o_result, exp_res);
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clock);
            chk({name, "_hold_valid"}, 32'(o_valid), 32'd1);
            chk({name, "_hold_result"}, o_result, exp_res);
            chk({name, "_hold_ready"}, 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clock);
        chk({name, "_ready_after"}, 32'(o_ready), 32'd1);
        chk({name, "_valid_after"}, 32'(o_valid), 32'd0);
        i_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // random op with random back-pressure, input noise and occasional flush
    task automatic rand_op();
        @(negedge i_clock);
        i_valid = 1'b1;
        i_func  = 3'($urandom_range(0, 7));
        i_src1  = pick();
        i_src2  = pick();
        i_ready = ($urandom_range(0, 2) != 0);
        i_flush = ($urandom_range(0, 15) == 0);
        for (int j = 0; j < 90; j++) begin
            @(negedge i_clock);
            if (!m_busy) break;
            i_valid = 1'($urandom_range(0, 1));
            i_func  = 3'($urandom_range(0, 7));
            i_src1  = $urandom;
            i_src2  = $urandom;
            i_ready = (j > 60) || ($urandom_range(0, 2) != 0);
            i_flush = (j < 60) && ($urandom_range(0, 39) == 0);
        end
        chk("rand_completes", 32'(m_busy), 32'd0);
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic start_divu_9_3_then_abort(input logic use_reset, input int wait_cycles);
        string tag;
        tag = use_reset ? "reset_abort" : "flush_abort";
        @(negedge i_clock);
        i_valid = 1'b1;
        i_func  = MDU_DIVU;
        i_src1  = 32'd1000;
        i_src2  = 32'd7;
        i_ready = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (wait_cycles) @(negedge i_clock);
        if (use_reset) begin
            #1 i_reset_n = 1'b0;
            @(negedge i_clock);
            chk({tag, "_result_zero"}, o_result, 32'h0);
            #1 i_reset_n = 1'b1;
        end else begin
            i_flush = 1'b1;
            @(negedge i_clock);
            i_flush = 1'b0;
        end
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clock);
            chk({tag, "_no_valid"}, 32'(o_valid), 32'd0);
        end
        i_ready = 1'b0;
        run_op({tag, "_divu93"}, MDU_DIVU, 32'd9, 32'd3, 0, 32'd3, 33);
    endtask

    initial begin
        // model pinned to hand-computed values
        chk("pin_mul",    ref_res(MDU_MUL,    32'd7,        32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("pin_mulh",   ref_res(MDU_MULH,   32'h80000000, 32'h80000000), 32'h40000000);
        chk("pin_mulhu",  ref_res(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
        chk("pin_mulhsu", ref_res(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        chk("pin_div",    ref_res(MDU_DIV,    32'hFFFFFFF9, 32'd2),        32'hFFFFFFFD);
        chk("pin_rem",    ref_res(MDU_REM,    32'hFFFFFFF9, 32'd2),        32'hFFFFFFFF);
        chk("pin_divu",   ref_res(MDU_DIVU,   32'd100,      32'd7),        32'd14);
        chk("pin_remu",   ref_res(MDU_REMU,   32'd100,      32'd7),        32'd2);
        chk("pin_div0",   ref_res(MDU_DIV,    32'd5,        32'd0),        32'hFFFFFFFF);
        chk("pin_rem0",   ref_res(MDU_REM,    32'd5,        32'd0),        32'd5);

        repeat (3) @(negedge i_clock);
        chk("reset_ready",  32'(o_ready), 32'd1);
        chk("reset_valid",  32'(o_valid), 32'd0);
        chk("reset_busy",   32'(o_busy),  32'd0);
        chk("reset_result", o_result,     32'h0);
        #1 i_reset_n = 1'b1;

        run_op("mul_7_m3",     MDU_MUL,    32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFEB, 33);
        run_op("mulh_min",     MDU_MULH,   32'h80000000, 32'h80000000, 0, 32'h40000000, 33);
        run_op("mulhu_max",    MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 33);
        run_op("mulhsu_m1",    MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 33);
        run_op("div_m7_2",     MDU_DIV,    32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2",     MDU_REM,    32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 33);
        run_op("divu_100_7",   MDU_DIVU,   32'd100,      32'd7,        0, 32'd14,       33);
        run_op("remu_100_7",   MDU_REMU,   32'd100,      32'd7,        0, 32'd2,        33);
        run_op("div_5_0",      MDU_DIV,    32'd5,        32'd0,        0, 32'hFFFFFFFF, 1);
        run_op("rem_5_0",      MDU_REM,    32'd5,        32'd0,        0, 32'd5,        1);
        run_op("div_ovf",      MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1);
        run_op("rem_ovf",      MDU_REM,    32'h80000000, 32'hFFFFFFFF, 0, 32'h0,        1);
        run_op("hold_mul",     MDU_MUL,    32'd1234,     32'd5678,     5, 32'd7006652,  33);
        run_op("hold_divu0",   MDU_DIVU,   32'd77,       32'd0,        5, 32'hFFFFFFFF, 1);

        // flush in IDLE together with a request: not accepted
        @(negedge i_clock);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_func  = MDU_MUL;
        @(negedge i_clock);
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("idle_flush_not_accepted", 32'(o_busy), 32'd0);

        start_divu_9_3_then_abort(1'b0, 10);
        start_divu_9_3_then_abort(1'b1, 15);

        for (int n = 0; n < 80; n++) rand_op();

        repeat (2) @(negedge i_clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
